// File: rtl/tt_io_pkg.sv
// Shared types and defaults for the tile input conditioning path.
// Debounce counters are built only with IN_COND_DEBOUNCE_EN defined.
package tt_io_pkg;

    localparam int UI_WIDTH            = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    typedef struct packed {
        logic clean;
        logic rise;
        logic fall;
    } cond_bit_t;

endpackage

// File: rtl/tt_in_cond_bit.sv
// One input bit: synchroniser, optional debounce counter, edge pulses.
// Debounce counter present only with IN_COND_DEBOUNCE_EN defined.
module tt_in_cond_bit
    import tt_io_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef IN_COND_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`endif
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ena,
    input  logic      din,
    output cond_bit_t q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   upd;
    logic                   clean_q;
    logic                   rise_q;
    logic                   fall_q;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

`ifdef IN_COND_DEBOUNCE_EN
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle where s matches clean, or ena is low, restarts the count.
    always_comb begin
        cnt_d = '0;
        upd   = 1'b0;
        if (ena && (s != clean_q)) begin
            if (cnt_q == CNT_MAX) begin
                upd = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign upd = ena && (s != clean_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= upd & s;
            fall_q <= upd & ~s;
            if (upd) begin
                clean_q <= s;
            end
        end
    end

    assign q = '{clean: clean_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/tt_in_conditioner.sv
// Tile input conditioner: per-bit sync, debounce and edge strobes.
// Define IN_COND_DEBOUNCE_EN to enable the debounce counters.
module tt_in_conditioner
    import tt_io_pkg::*;
#(
    parameter int WIDTH           = UI_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cond_bit_t q;

        tt_in_cond_bit #(
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef IN_COND_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .ena   (ena),
            .din   (ui_in[i]),
            .q     (q)
        );

        assign clean[i] = q.clean;
        assign rise[i]  = q.rise;
        assign fall[i]  = q.fall;
    end

endmodule

// File: tb/tb_tt_in_conditioner.sv
// Directed bench for tt_in_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected latencies follow IN_COND_DEBOUNCE_EN.
module tb_tt_in_conditioner;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 4;
`ifdef IN_COND_DEBOUNCE_EN
    localparam int LAT     = SS - 1 + DC;
    localparam int DEB_EFF = DC;
    localparam int PRE     = 4;
`else
    localparam int LAT     = SS;
    localparam int DEB_EFF = 1;
    localparam int PRE     = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] ui_in;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    tt_in_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .ui_in (ui_in),
        .clean (clean),
        .rise  (rise),
        .fall  (fall)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle_low();
        ui_in = '0;
        step(LAT + 3);
    endtask

    task automatic test_reset();
        logic [W-1:0] ec, er;
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = 8'hFF;
        step(3);
        n_chk++;
        if (clean !== 8'h00) $display("FAIL reset_clean: got %h want 00", clean);
        else n_pass++;
        n_chk++;
        if (rise !== 8'h00) $display("FAIL reset_rise: got %h want 00", rise);
        else n_pass++;
        n_chk++;
        if (fall !== 8'h00) $display("FAIL reset_fall: got %h want 00", fall);
        else n_pass++;
        rst_n = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1);
            ec = (c >= LAT + 1) ? 8'hFF : 8'h00;
            er = (c == LAT + 1) ? 8'hFF : 8'h00;
            n_chk++;
            if (clean !== ec) $display("FAIL rel_clean c%0d: got %h want %h", c, clean, ec);
            else n_pass++;
            n_chk++;
            if (rise !== er) $display("FAIL rel_rise c%0d: got %h want %h", c, rise, er);
            else n_pass++;
        end
        settle_low();
        n_chk++;
        if (clean !== 8'h00) $display("FAIL settle_clean: got %h want 00", clean);
        else n_pass++;
    endtask

    task automatic test_step();
        logic [W-1:0] ec, ep;
        ui_in = 8'h01;
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1);
            ec = (c >= LAT + 1) ? 8'h01 : 8'h00;
            ep = (c == LAT + 1) ? 8'h01 : 8'h00;
            n_chk++;
            if (clean !== ec) $display("FAIL up_clean c%0d: got %h want %h", c, clean, ec);
            else n_pass++;
            n_chk++;
            if (rise !== ep) $display("FAIL up_rise c%0d: got %h want %h", c, rise, ep);
            else n_pass++;
            n_chk++;
            if (fall !== 8'h00) $display("FAIL up_fall c%0d: got %h want 00", c, fall);
            else n_pass++;
        end
        ui_in = 8'h00;
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1);
            ec = (c >= LAT + 1) ? 8'h00 : 8'h01;
            ep = (c == LAT + 1) ? 8'h01 : 8'h00;
            n_chk++;
            if (clean !== ec) $display("FAIL dn_clean c%0d: got %h want %h", c, clean, ec);
            else n_pass++;
            n_chk++;
            if (fall !== ep) $display("FAIL dn_fall c%0d: got %h want %h", c, fall, ep);
            else n_pass++;
            n_chk++;
            if (rise !== 8'h00) $display("FAIL dn_rise c%0d: got %h want 00", c, rise);
            else n_pass++;
        end
    endtask

`ifdef IN_COND_DEBOUNCE_EN
    task automatic test_glitch();
        logic [W-1:0] ec, ep;
        ui_in = 8'h08;
        step(3);
        ui_in = 8'h00;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            n_chk++;
            if (clean !== 8'h00) $display("FAIL gl_clean c%0d: got %h want 00", c, clean);
            else n_pass++;
            n_chk++;
            if (rise !== 8'h00) $display("FAIL gl_rise c%0d: got %h want 00", c, rise);
            else n_pass++;
        end
        ui_in = 8'h08;
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1);
            ec = (c >= LAT + 1) ? 8'h08 : 8'h00;
            ep = (c == LAT + 1) ? 8'h08 : 8'h00;
            n_chk++;
            if (clean !== ec) $display("FAIL gl4_clean c%0d: got %h want %h", c, clean, ec);
            else n_pass++;
            n_chk++;
            if (rise !== ep) $display("FAIL gl4_rise c%0d: got %h want %h", c, rise, ep);
            else n_pass++;
        end
        settle_low();
    endtask
`else
    task automatic test_pulse();
        logic [W-1:0] ec, er, ef;
        ui_in = 8'h20;
        for (int c = 1; c <= 5; c++) begin
            step(1);
            ui_in = 8'h00;
            ec = (c == 3) ? 8'h20 : 8'h00;
            er = (c == 3) ? 8'h20 : 8'h00;
            ef = (c == 4) ? 8'h20 : 8'h00;
            n_chk++;
            if (clean !== ec) $display("FAIL pu_clean c%0d: got %h want %h", c, clean, ec);
            else n_pass++;
            n_chk++;
            if (rise !== er) $display("FAIL pu_rise c%0d: got %h want %h", c, rise, er);
            else n_pass++;
            n_chk++;
            if (fall !== ef) $display("FAIL pu_fall c%0d: got %h want %h", c, fall, ef);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_stagger();
        logic [W-1:0] er;
        ui_in = 8'h02;
        for (int c = 1; c <= LAT + 5; c++) begin
            step(1);
            if (c == 2) ui_in = 8'h42;
            er = (c == LAT + 1) ? 8'h02 :
                 (c == LAT + 3) ? 8'h40 : 8'h00;
            n_chk++;
            if (rise !== er) $display("FAIL st_rise c%0d: got %h want %h", c, rise, er);
            else n_pass++;
        end
        n_chk++;
        if (clean !== 8'h42) $display("FAIL st_clean: got %h want 42", clean);
        else n_pass++;
        settle_low();
    endtask

    task automatic test_ena_mid();
        logic [W-1:0] ec, er;
        ui_in = 8'h04;
        step(PRE);
        ena = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step(1);
            n_chk++;
            if (clean !== 8'h00) $display("FAIL en0_clean c%0d: got %h want 00", c, clean);
            else n_pass++;
            n_chk++;
            if (rise !== 8'h00) $display("FAIL en0_rise c%0d: got %h want 00", c, rise);
            else n_pass++;
        end
        ena = 1'b1;
        for (int c = 1; c <= DEB_EFF + 1; c++) begin
            step(1);
            ec = (c >= DEB_EFF) ? 8'h04 : 8'h00;
            er = (c == DEB_EFF) ? 8'h04 : 8'h00;
            n_chk++;
            if (clean !== ec) $display("FAIL en1_clean c%0d: got %h want %h", c, clean, ec);
            else n_pass++;
            n_chk++;
            if (rise !== er) $display("FAIL en1_rise c%0d: got %h want %h", c, rise, er);
            else n_pass++;
        end
        ui_in = 8'h14;
        step(2);
        rst_n = 1'b0;
        step(1);
        n_chk++;
        if (clean !== 8'h00) $display("FAIL mrst_clean: got %h want 00", clean);
        else n_pass++;
        n_chk++;
        if (rise !== 8'h00) $display("FAIL mrst_rise: got %h want 00", rise);
        else n_pass++;
        n_chk++;
        if (fall !== 8'h00) $display("FAIL mrst_fall: got %h want 00", fall);
        else n_pass++;
        ui_in = 8'h00;
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = '0;
        test_reset();
        test_step();
`ifdef IN_COND_DEBOUNCE_EN
        test_glitch();
`else
        test_pulse();
`endif
        test_stagger();
        test_ena_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
